// File: rtl/wcoder_pkg.sv
// ============================================================================
// wcoder_pkg : shared constants and types for the block-weight byte link
// Rev 1.0
// ============================================================================
`default_nettype none

package wcoder_pkg;

    localparam int DEFAULT_SUM_W     = 16;
    localparam int DEFAULT_BLK_IDX_W = 4;
    localparam int BYTES_PER_WORD    = 2 * DEFAULT_SUM_W / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/wdecoder_if.sv
// ============================================================================
// wdecoder_if : byte-link input and valid/ready result port of the decoder
// Rev 1.0
// ============================================================================
`default_nettype none

interface wdecoder_if
    import wcoder_pkg::*;
#(
    parameter int SUM_W     = DEFAULT_SUM_W,
    parameter int BLK_IDX_W = DEFAULT_BLK_IDX_W
);
    logic                 frame_start;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SUM_W-1:0]     out_sum_l;
    logic [SUM_W-1:0]     out_sum_r;
    logic [SUM_W:0]       out_diff;
    logic [BLK_IDX_W-1:0] out_blk;
    logic                 err_trunc;
    logic                 err_ovf;

    modport master (
        output frame_start, in_valid, in_data, out_ready,
        input  out_valid, out_sum_l, out_sum_r, out_diff, out_blk,
               err_trunc, err_ovf
    );

    modport slave (
        input  frame_start, in_valid, in_data, out_ready,
        output out_valid, out_sum_l, out_sum_r, out_diff, out_blk,
               err_trunc, err_ovf
    );
endinterface

`default_nettype wire

// File: rtl/wdec_assembler.sv
// ============================================================================
// wdec_assembler : byte shift register, byte counter and IDLE/RECV FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module wdec_assembler
    import wcoder_pkg::*;
#(
    parameter int WORD_W = 8 * BYTES_PER_WORD
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              frame_start,
    input  wire logic              in_valid,
    input  wire logic [7:0]        in_data,
    output logic                   word_done,
    output logic [WORD_W-1:0]      word,
    output logic                   trunc
);
    localparam int NBYTES = WORD_W / 8;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam int SH_W   = WORD_W - 8;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SH_W-1:0]  r_shift;

    // Completion and truncation are decoded from the byte being sampled this
    // edge, so the top can load its result register with one cycle latency.
    assign word_done = (r_state == RECV) && in_valid && !frame_start && (r_cnt == C_LAST);
    assign trunc     = (r_state == RECV) && !in_valid && !frame_start;
    assign word      = {r_shift, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (frame_start) begin
            // A concurrent byte opens the first word of the new frame.
            if (in_valid) begin
                r_state <= RECV;
                r_cnt   <= C_ONE;
                r_shift <= {{(SH_W-8){1'b0}}, in_data};
            end else begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= RECV;
                        r_cnt   <= C_ONE;
                        r_shift <= {r_shift[SH_W-9:0], in_data};
                    end
                end
                RECV: begin
                    if (!in_valid || (r_cnt == C_LAST)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + C_ONE;
                        r_shift <= {r_shift[SH_W-9:0], in_data};
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/wdecoder.sv
// ============================================================================
// wdecoder : block-weight byte link receiver with balance and error flags
// Rev 1.0
// ============================================================================
`default_nettype none

module wdecoder
    import wcoder_pkg::*;
#(
    parameter int SUM_W     = DEFAULT_SUM_W,
    parameter int BLK_IDX_W = DEFAULT_BLK_IDX_W
) (
    input  wire logic dclk,
    input  wire logic rst,
    wdecoder_if.slave bus
);
    localparam int WORD_W = 2 * SUM_W;

    logic                 w_word_done;
    logic                 w_trunc;
    logic [WORD_W-1:0]    w_word;
    logic [SUM_W-1:0]     w_sum_l;
    logic [SUM_W-1:0]     w_sum_r;
    logic [SUM_W:0]       w_diff;
    logic                 w_free;

    logic                 r_valid;
    logic [SUM_W-1:0]     r_sum_l;
    logic [SUM_W-1:0]     r_sum_r;
    logic [SUM_W:0]       r_diff;
    logic [BLK_IDX_W-1:0] r_out_blk;
    logic [BLK_IDX_W-1:0] r_blk_cnt;
    logic                 r_err_trunc;
    logic                 r_err_ovf;

    wdec_assembler #(
        .WORD_W (WORD_W)
    ) u_asm (
        .clk         (dclk),
        .rst         (rst),
        .frame_start (bus.frame_start),
        .in_valid    (bus.in_valid),
        .in_data     (bus.in_data),
        .word_done   (w_word_done),
        .word        (w_word),
        .trunc       (w_trunc)
    );

    assign w_sum_l = w_word[WORD_W-1:SUM_W];
    assign w_sum_r = w_word[SUM_W-1:0];
    assign w_diff  = {1'b0, w_sum_l} - {1'b0, w_sum_r};
    assign w_free  = !r_valid || bus.out_ready;

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_sum_l     <= '0;
            r_sum_r     <= '0;
            r_diff      <= '0;
            r_out_blk   <= '0;
            r_blk_cnt   <= '0;
            r_err_trunc <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            if (w_word_done && w_free) begin
                r_valid   <= 1'b1;
                r_sum_l   <= w_sum_l;
                r_sum_r   <= w_sum_r;
                r_diff    <= w_diff;
                r_out_blk <= r_blk_cnt;
            end else if (r_valid && bus.out_ready) begin
                r_valid   <= 1'b0;
            end

            // Dropped words still advance the index to stay aligned with the encoder.
            if (bus.frame_start) begin
                r_blk_cnt   <= '0;
                r_err_trunc <= 1'b0;
                r_err_ovf   <= 1'b0;
            end else begin
                if (w_word_done)
                    r_blk_cnt <= r_blk_cnt + BLK_IDX_W'(1);
                if (w_trunc)
                    r_err_trunc <= 1'b1;
                if (w_word_done && !w_free)
                    r_err_ovf <= 1'b1;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_sum_l = r_sum_l;
    assign bus.out_sum_r = r_sum_r;
    assign bus.out_diff  = r_diff;
    assign bus.out_blk   = r_out_blk;
    assign bus.err_trunc = r_err_trunc;
    assign bus.err_ovf   = r_err_ovf;

endmodule

`default_nettype wire
